uart_mmio_resp: RTL and testbench
=================================

# uart_mmio_resp

Memory-mapped UART responder on the core's data bus. Decodes the core's RAM-port requests (CE/RD/WR/ADDR/DATA), provides a 4-entry TX FIFO driving an 8N1 serial transmitter and a single-byte 8N1 receiver, and raises a level interrupt to the core. It is the bus-side counterpart of the core's data-bus initiator and replaces the ad-hoc UART hookup at SoC top.

## Interface
- BAUD_DIV, 868: reset value of the baud divider (clocks per bit; 100 MHz / 115200).
- TX_DEPTH, 4: TX FIFO entries; must be a power of 2.
- iCLK  in  1  system clock, all logic rising-edge.
- iRST  in  1  reset; asynchronous and active-low.
- iBUS_CE  in  1  chip enable; the request is valid only when high.
- iBUS_RD  in  1  read strobe.
- iBUS_WR  in  1  write strobe.
- iBUS_ADDR  in  32  byte address; only [3:2] decoded.
- iBUS_DATA  in  32  write data.
- oBUS_DATA  out  32  registered read data.
- iUART_RXD  in  1  serial input; asynchronous to iCLK.
- oUART_TXD  out  1  serial output, idle high.
- oIRQ  out  1  level interrupt.

## Operation
- Register map (ADDR[3:2]):
  - 0 DATA: write pushes DATA[7:0] into the TX FIFO; read returns {24'b0, rx_byte} and clears rx_valid.
  - 1 STATUS (read): bit0 tx_full, bit1 tx_empty (FIFO empty and shifter idle), bit2 rx_valid, bit3 rx_overrun, bit4 tx_busy, bit5 rx_frame_err. Writing 1 to bit3 or bit5 clears that bit.
  - 2 CTRL (R/W): bit0 irq_rx_en, bit1 irq_txempty_en.
  - 3 BAUD (R/W): [15:0] divider. Writes below 4 are stored as 4.
- oIRQ = (irq_rx_en & rx_valid) | (irq_txempty_en & tx_empty).
- If WR and RD are both asserted in the same cycle, the write is performed, the read is ignored and oBUS_DATA holds its value.
- Write to DATA while the FIFO is full: data dropped silently; no state changes.
- TX engine states IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE, or STOP→START if the FIFO is not empty. The divider is latched at START; a BAUD write during a frame applies from the next frame.
- RX path: 2-FF synchronizer. States IDLE→START→DATA→STOP:
  - Start is detected on a falling edge; the line is re-sampled at div/2 and the receiver returns to IDLE if it is high (glitch).
  - Data bits are sampled at bit centres.
  - A low stop bit sets rx_frame_err and the byte is discarded.
  - A good stop bit loads rx_byte and sets rx_valid. If rx_valid was already set, the new byte overwrites it and rx_overrun is set (sticky).
  - If a DATA read and a byte completion happen in the same cycle, the new byte wins: rx_valid stays 1 and overrun is not set.

## Timing
- Reset values: oUART_TXD=1, oBUS_DATA=0, oIRQ=0, FIFO empty, CTRL=0, BAUD=BAUD_DIV, all status flags 0. Reset mid-frame forces TXD high immediately.
- Read latency is 1 cycle: a request at edge N appears on oBUS_DATA after edge N+1, and the value holds until the next read.
- A write at edge N updates registers and FIFO count at edge N+1.
- If TX is idle, the start bit drives oUART_TXD from edge N+2.
- Each bit lasts exactly div cycles, so a frame is 10×div cycles. Back-to-back frames have no idle gap.
- rx_valid rises 1 cycle after the stop-bit centre sample.

## Configuration
- UART_RX_EN defined: the receiver, rx status bits, irq_rx term and iUART_RXD are used.
- UART_RX_EN undefined: TX-only. DATA reads return 0; STATUS bits 2, 3 and 5 read 0; CTRL bit0 reads 0; iUART_RXD is ignored.

## Structure
- Package uart_mmio_pkg holds:
  - Register offsets (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_BAUD=2'd3).
  - STATUS bit positions.
  - TX/RX state encodings.
  - The minimum divider constant (4).
- Sub-module uart_rx_sampler holds the synchronizer and RX FSM; it is instantiated only under UART_RX_EN. TX FIFO and TX FSM stay in the top.

## Test plan
- Reset: assert iRST=0 mid-frame → TXD=1, STATUS reads 0x02, BAUD reads BAUD_DIV.
- TX: BAUD=16, write 0x55 to DATA → TXD start bit at write+2, pattern 0,1,0,1,0,1,0,1,0,1 at 16 cycles/bit; tx_empty returns to 1 after 160 cycles.
- FIFO: write 0x01..0x06 back-to-back →
  - tx_full reads 1 after the 5th write (4 buffered + 1 in shifter);
  - the 6th byte is dropped;
  - exactly 5 gapless frames appear.
- RX: BAUD=16, drive 0xA3 on RXD → rx_valid=1, oIRQ=1 with irq_rx_en set; a DATA read returns 0x000000A3 next cycle and rx_valid clears.
- RX errors:
  - send two bytes without reading → rx_overrun=1 and DATA reads the 2nd byte;
  - send a frame with stop bit 0 → rx_frame_err=1 and rx_valid=0;
  - write STATUS 0x28 → both flags clear.
- Bus corner: CE=1 with RD=WR=1 on BAUD and data 2 → BAUD reads 4 and oBUS_DATA is unchanged that cycle. Same stimulus with CE=0 → no change.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, STATUS bit positions, TX/RX state
// encodings and the divider clamp shared by the memory-mapped UART responder.
package uart_mmio_pkg;

   // Register offsets decoded from ADDR[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_BAUD   = 2'd3;

   // STATUS bit positions
   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_RX_VALID     = 2;
   localparam int ST_RX_OVERRUN   = 3;
   localparam int ST_TX_BUSY      = 4;
   localparam int ST_RX_FRAME_ERR = 5;

   // Smallest divider the bit timing logic supports
   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Raise too-small divider writes to the minimum supported value
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-FF synchronizer and 8N1 receive FSM. Emits a one-cycle
// done pulse with the byte on a good stop bit, or a frame_err pulse when the
// stop bit is low. A start edge that is high again at mid-bit is a glitch.
module uart_rx_sampler
   import uart_mmio_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rxd,
   input  logic [15:0] div,
   output logic        done,
   output logic        frame_err,
   output logic [7:0]  data
);

   logic        sync1_r, sync2_r, prev_r;
   rx_state_e   state_r, state_s;
   logic [15:0] cnt_r, cnt_s, div_r, div_s;
   logic [2:0]  bit_r, bit_s;
   logic [7:0]  shift_r, shift_s;
   logic        done_r, done_s, ferr_r, ferr_s;
   logic        mid_s, last_s;

   assign mid_s     = (cnt_r == ({1'b0, div_r[15:1]} - 16'd1));
   assign last_s    = (cnt_r == (div_r - 16'd1));
   assign done      = done_r;
   assign frame_err = ferr_r;
   assign data      = shift_r;

   // Synchronize the asynchronous line and keep the previous level for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rxd;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Receive state register and registered result pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RX_IDLE;
         cnt_r   <= 16'd0;
         div_r   <= MIN_DIV;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         done_r  <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         div_r   <= div_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         done_r  <= done_s;
         ferr_r  <= ferr_s;
      end
   end

   // Next-state logic: start validation at mid-bit, data at bit centres
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      div_s   = div_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      done_s  = 1'b0;
      ferr_s  = 1'b0;
      case (state_r)
         RX_IDLE: begin
            if (prev_r && !sync2_r) begin
               state_s = RX_START;
               cnt_s   = 16'd0;
               div_s   = div;
            end else begin
               cnt_s = 16'd0;
            end
         end
         RX_START: begin
            if (mid_s) begin
               cnt_s = 16'd0;
               bit_s = 3'd0;
               if (sync2_r) begin
                  state_s = RX_IDLE;
               end else begin
                  state_s = RX_DATA;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         RX_DATA: begin
            if (last_s) begin
               cnt_s   = 16'd0;
               shift_s = {sync2_r, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = RX_STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         RX_STOP: begin
            if (last_s) begin
               cnt_s   = 16'd0;
               state_s = RX_IDLE;
               if (sync2_r) begin
                  done_s = 1'b1;
               end else begin
                  ferr_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = RX_IDLE;
            cnt_s   = 16'd0;
         end
      endcase
   end

endmodule

// File: rtl/uart_mmio_resp.sv
// uart_mmio_resp: memory-mapped UART responder on the core data bus.
// Bus requests are registered on entry, so reads return one cycle after the
// request edge and writes take effect one cycle later. TX FIFO and TX FSM
// live here; the receiver (uart_rx_sampler) is built only when the macro
// UART_RX_EN is defined, otherwise the block is TX-only and RX bits read 0.
module uart_mmio_resp
   import uart_mmio_pkg::*;
#(
   parameter int BAUD_DIV = 868,
   parameter int TX_DEPTH = 4
)
(
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iBUS_CE,
   input  logic        iBUS_RD,
   input  logic        iBUS_WR,
   input  logic [31:0] iBUS_ADDR,
   input  logic [31:0] iBUS_DATA,
   output logic [31:0] oBUS_DATA,
   input  logic        iUART_RXD,
   output logic        oUART_TXD,
   output logic        oIRQ
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);

   // Registered bus request
   logic        req_ce_r, req_rd_r, req_wr_r;
   logic [1:0]  req_addr_r;
   logic [15:0] req_data_r;
   logic        wr_en_s, rd_en_s, data_wr_s, data_rd_s, status_wr_s, ctrl_wr_s, baud_wr_s;
   // Registers and flags
   logic        ctrl_rxe_r, ctrl_txe_r;
   logic [15:0] baud_r;
   logic [7:0]  rx_byte_r;
   logic        rx_valid_r, rx_overrun_r, rx_ferr_r;
   logic [31:0] bus_data_r, rd_data_s;
   logic        irq_r;
   logic [5:0]  status_s;
   // TX FIFO
   logic [7:0]    fifo_mem_r [TX_DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic [PW:0]   count_r;
   logic          fifo_full_s, fifo_empty_s, push_s, pop_s;
   // TX engine
   tx_state_e   tx_state_r, tx_state_s;
   logic [15:0] tx_cnt_r, tx_cnt_s, tx_div_r, tx_div_s;
   logic [2:0]  tx_bit_r, tx_bit_s;
   logic [7:0]  tx_shift_r, tx_shift_s;
   logic        txd_r, txd_s, tx_last_s, tx_empty_s, tx_busy_s;
   // Receiver interface
   logic        rx_done_s, rx_ferr_s;
   logic [7:0]  rx_data_s;
   logic        unused_s;

`ifdef UART_RX_EN
   localparam logic RX_ON = 1'b1;
   uart_rx_sampler u_rx_sampler (
      .clk       (iCLK),
      .rst_n     (iRST),
      .rxd       (iUART_RXD),
      .div       (baud_r),
      .done      (rx_done_s),
      .frame_err (rx_ferr_s),
      .data      (rx_data_s)
   );
   assign unused_s = ^{iBUS_ADDR[31:4], iBUS_ADDR[1:0], iBUS_DATA[31:16]};
`else
   localparam logic RX_ON = 1'b0;
   assign rx_done_s = 1'b0;
   assign rx_ferr_s = 1'b0;
   assign rx_data_s = 8'h00;
   assign unused_s  = ^{iBUS_ADDR[31:4], iBUS_ADDR[1:0], iBUS_DATA[31:16], iUART_RXD};
`endif

   // A simultaneous read and write is treated as a write only
   assign wr_en_s     = req_ce_r & req_wr_r;
   assign rd_en_s     = req_ce_r & req_rd_r & ~req_wr_r;
   assign data_wr_s   = wr_en_s & (req_addr_r == REG_DATA);
   assign status_wr_s = wr_en_s & (req_addr_r == REG_STATUS);
   assign ctrl_wr_s   = wr_en_s & (req_addr_r == REG_CTRL);
   assign baud_wr_s   = wr_en_s & (req_addr_r == REG_BAUD);
   assign data_rd_s   = rd_en_s & (req_addr_r == REG_DATA);

   assign fifo_full_s  = (count_r == DEPTH_C);
   assign fifo_empty_s = (count_r == '0);
   assign push_s       = data_wr_s & ~fifo_full_s;
   assign tx_last_s    = (tx_cnt_r == (tx_div_r - 16'd1));
   assign tx_empty_s   = fifo_empty_s & (tx_state_r == TX_IDLE);
   assign tx_busy_s    = (tx_state_r != TX_IDLE);

   assign oBUS_DATA = bus_data_r;
   assign oUART_TXD = txd_r;
   assign oIRQ      = irq_r;

   // Capture the bus request for decoding in the following cycle
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         req_ce_r   <= 1'b0;
         req_rd_r   <= 1'b0;
         req_wr_r   <= 1'b0;
         req_addr_r <= 2'd0;
         req_data_r <= 16'h0000;
      end else begin
         req_ce_r   <= iBUS_CE;
         req_rd_r   <= iBUS_RD;
         req_wr_r   <= iBUS_WR;
         req_addr_r <= iBUS_ADDR[3:2];
         req_data_r <= iBUS_DATA[15:0];
      end
   end

   // CTRL and BAUD register writes
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         ctrl_rxe_r <= 1'b0;
         ctrl_txe_r <= 1'b0;
         baud_r     <= 16'(BAUD_DIV);
      end else begin
         if (ctrl_wr_s) begin
            ctrl_rxe_r <= req_data_r[0];
            ctrl_txe_r <= req_data_r[1];
         end
         if (baud_wr_s) begin
            baud_r <= clamp_div(req_data_r);
         end
      end
   end

   // RX byte and flags; a completing byte beats a same-cycle DATA read
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         rx_byte_r    <= 8'h00;
         rx_valid_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
         rx_ferr_r    <= 1'b0;
      end else begin
         if (rx_done_s) begin
            rx_byte_r  <= rx_data_s;
            rx_valid_r <= 1'b1;
         end else if (data_rd_s) begin
            rx_valid_r <= 1'b0;
         end
         if (rx_done_s && rx_valid_r && !data_rd_s) begin
            rx_overrun_r <= 1'b1;
         end else if (status_wr_s && req_data_r[ST_RX_OVERRUN]) begin
            rx_overrun_r <= 1'b0;
         end
         if (rx_ferr_s) begin
            rx_ferr_r <= 1'b1;
         end else if (status_wr_s && req_data_r[ST_RX_FRAME_ERR]) begin
            rx_ferr_r <= 1'b0;
         end
      end
   end

   // TX FIFO storage and occupancy; writes while full are dropped
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         for (int i = 0; i < TX_DEPTH; i++) begin
            fifo_mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= req_data_r[7:0];
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // TX engine state register; TXD is forced high by reset
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= 16'd0;
         tx_div_r   <= MIN_DIV;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         txd_r      <= 1'b1;
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_div_r   <= tx_div_s;
         tx_bit_r   <= tx_bit_s;
         tx_shift_r <= tx_shift_s;
         txd_r      <= txd_s;
      end
   end

   // TX next state; a frame starts straight from STOP when more data waits
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_div_s   = tx_div_r;
      tx_bit_s   = tx_bit_r;
      tx_shift_s = tx_shift_r;
      txd_s      = txd_r;
      pop_s      = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s      = 1'b1;
               tx_state_s = TX_START;
               tx_shift_s = fifo_mem_r[rd_ptr_r];
               tx_div_s   = baud_r;
               tx_cnt_s   = 16'd0;
               txd_s      = 1'b0;
            end else begin
               txd_s = 1'b1;
            end
         end
         TX_START: begin
            if (tx_last_s) begin
               tx_state_s = TX_DATA;
               tx_cnt_s   = 16'd0;
               tx_bit_s   = 3'd0;
               txd_s      = tx_shift_r[0];
            end else begin
               tx_cnt_s = tx_cnt_r + 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_last_s) begin
               tx_cnt_s = 16'd0;
               if (tx_bit_r == 3'd7) begin
                  tx_state_s = TX_STOP;
                  txd_s      = 1'b1;
               end else begin
                  tx_bit_s   = tx_bit_r + 3'd1;
                  tx_shift_s = {1'b0, tx_shift_r[7:1]};
                  txd_s      = tx_shift_r[1];
               end
            end else begin
               tx_cnt_s = tx_cnt_r + 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_last_s) begin
               tx_cnt_s = 16'd0;
               if (!fifo_empty_s) begin
                  pop_s      = 1'b1;
                  tx_state_s = TX_START;
                  tx_shift_s = fifo_mem_r[rd_ptr_r];
                  tx_div_s   = baud_r;
                  txd_s      = 1'b0;
               end else begin
                  tx_state_s = TX_IDLE;
                  txd_s      = 1'b1;
               end
            end else begin
               tx_cnt_s = tx_cnt_r + 16'd1;
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            tx_cnt_s   = 16'd0;
            txd_s      = 1'b1;
         end
      endcase
   end

   // Assemble STATUS; receiver bits read 0 in a TX-only build
   always_comb begin
      status_s                  = 6'b000000;
      status_s[ST_TX_FULL]      = fifo_full_s;
      status_s[ST_TX_EMPTY]     = tx_empty_s;
      status_s[ST_RX_VALID]     = rx_valid_r & RX_ON;
      status_s[ST_RX_OVERRUN]   = rx_overrun_r & RX_ON;
      status_s[ST_TX_BUSY]      = tx_busy_s;
      status_s[ST_RX_FRAME_ERR] = rx_ferr_r & RX_ON;
   end

   // Read data multiplexer
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (req_addr_r)
         REG_DATA:   rd_data_s = {24'h000000, rx_byte_r & {8{RX_ON}}};
         REG_STATUS: rd_data_s = {26'h0000000, status_s};
         REG_CTRL:   rd_data_s = {30'h00000000, ctrl_txe_r, ctrl_rxe_r & RX_ON};
         REG_BAUD:   rd_data_s = {16'h0000, baud_r};
         default:    rd_data_s = 32'h0000_0000;
      endcase
   end

   // Registered read data (held between reads) and level interrupt
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         bus_data_r <= 32'h0000_0000;
         irq_r      <= 1'b0;
      end else begin
         if (rd_en_s) begin
            bus_data_r <= rd_data_s;
         end else begin
            bus_data_r <= bus_data_r;
         end
         irq_r <= (ctrl_rxe_r & RX_ON & rx_valid_r) | (ctrl_txe_r & tx_empty_s);
      end
   end

endmodule

// File: tb/tb_uart_mmio_resp.sv
// tb_uart_mmio_resp: directed self-checking bench for uart_mmio_resp.
// RX scenarios are compiled in only when UART_RX_EN is defined.
module tb_uart_mmio_resp;

   localparam int BAUD_DIV = 868;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iBUS_CE = 1'b0, iBUS_RD = 1'b0, iBUS_WR = 1'b0;
   logic [31:0] iBUS_ADDR = 32'h0, iBUS_DATA = 32'h0;
   logic [31:0] oBUS_DATA;
   logic        iUART_RXD = 1'b1;
   logic        oUART_TXD, oIRQ;

   int          n_checks = 0;
   int          n_fail = 0;
   int          lows;
   logic [31:0] rdata;

   uart_mmio_resp #(.BAUD_DIV(BAUD_DIV), .TX_DEPTH(4)) dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iBUS_CE   (iBUS_CE),
      .iBUS_RD   (iBUS_RD),
      .iBUS_WR   (iBUS_WR),
      .iBUS_ADDR (iBUS_ADDR),
      .iBUS_DATA (iBUS_DATA),
      .oBUS_DATA (oBUS_DATA),
      .iUART_RXD (iUART_RXD),
      .oUART_TXD (oUART_TXD),
      .oIRQ      (oIRQ)
   );

   always #5 iCLK = ~iCLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge iCLK);
      iBUS_CE = 1'b1; iBUS_WR = 1'b1; iBUS_RD = 1'b0;
      iBUS_ADDR = addr; iBUS_DATA = data;
      @(posedge iCLK); #1;
      iBUS_CE = 1'b0; iBUS_WR = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge iCLK);
      iBUS_CE = 1'b1; iBUS_RD = 1'b1; iBUS_WR = 1'b0; iBUS_ADDR = addr;
      @(posedge iCLK); #1;
      iBUS_CE = 1'b0; iBUS_RD = 1'b0;
      @(posedge iCLK); #1;
      data = oBUS_DATA;
   endtask

   // Entered #1 after the edge that starts the start bit; checks first and
   // last cycle of every bit, returns #1 after the edge ending the stop bit.
   task automatic check_frame(input logic [7:0] b, input int div, input string tag);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         check_val($sformatf("%s_bit%0d_first", tag, i), {31'd0, oUART_TXD}, {31'd0, bits[i]});
         repeat (div - 1) begin @(posedge iCLK); #1; end
         check_val($sformatf("%s_bit%0d_last", tag, i), {31'd0, oUART_TXD}, {31'd0, bits[i]});
         @(posedge iCLK); #1;
      end
   endtask

   task automatic wait_start(input string tag, input int limit);
      int n;
      n = 0;
      while (oUART_TXD !== 1'b0 && n < limit) begin
         @(posedge iCLK); #1;
         n++;
      end
      check_val(tag, {31'd0, oUART_TXD}, 32'd0);
   endtask

`ifdef UART_RX_EN
   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge iCLK); iUART_RXD = bits[i];
         repeat (15) @(negedge iCLK);
      end
      @(negedge iCLK); iUART_RXD = 1'b1;
      repeat (32) @(negedge iCLK);
   endtask
`endif

   initial begin
      // Reset values
      repeat (3) @(posedge iCLK);
      #1;
      check_val("rst_txd", {31'd0, oUART_TXD}, 32'd1);
      check_val("rst_bus_data", oBUS_DATA, 32'd0);
      check_val("rst_irq", {31'd0, oIRQ}, 32'd0);
      @(negedge iCLK); iRST = 1'b1;
      bus_read(32'h4, rdata); check_val("rst_status", rdata, 32'h02);
      bus_read(32'hC, rdata); check_val("rst_baud", rdata, 32'(BAUD_DIV));
      bus_read(32'h8, rdata); check_val("rst_ctrl", rdata, 32'h0);
      bus_read(32'h0, rdata); check_val("rst_data", rdata, 32'h0);

      // Single frame: start bit from write edge +2, 16 cycles per bit
      bus_write(32'hC, 32'd16);
      bus_read(32'hC, rdata); check_val("baud16", rdata, 32'd16);
      bus_write(32'h0, 32'h55);
      @(posedge iCLK); #1; check_val("tx_idle_n1", {31'd0, oUART_TXD}, 32'd1);
      @(posedge iCLK); #1; check_val("tx_start_n2", {31'd0, oUART_TXD}, 32'd0);
      check_frame(8'h55, 16, "f55");
      bus_read(32'h4, rdata); check_val("tx_empty_after", rdata, 32'h02);

      // FIFO: six back-to-back writes, the sixth is dropped, five gapless frames
      fork
         begin
            wait_start("fifo_first_start", 50);
            for (int k = 1; k <= 5; k++) begin
               check_frame(8'(k), 16, $sformatf("fifo%0d", k));
            end
            lows = 0;
            repeat (48) begin
               if (oUART_TXD === 1'b0) lows++;
               @(posedge iCLK); #1;
            end
            check_val("fifo_no_sixth", lows, 32'd0);
         end
         begin
            @(negedge iCLK);
            iBUS_CE = 1'b1; iBUS_WR = 1'b1; iBUS_ADDR = 32'h0;
            for (int k = 1; k <= 6; k++) begin
               iBUS_DATA = 32'(k);
               @(posedge iCLK); #1;
            end
            iBUS_CE = 1'b0; iBUS_WR = 1'b0;
            bus_read(32'h4, rdata); check_val("fifo_full_status", rdata, 32'h11);
         end
      join
      bus_read(32'h4, rdata); check_val("fifo_drained", rdata, 32'h02);

      // Bus corner: RD and WR together writes, read ignored
      bus_read(32'h4, rdata); check_val("corner_pre", rdata, 32'h02);
      @(negedge iCLK);
      iBUS_CE = 1'b1; iBUS_RD = 1'b1; iBUS_WR = 1'b1; iBUS_ADDR = 32'hC; iBUS_DATA = 32'd2;
      @(posedge iCLK); #1;
      iBUS_CE = 1'b0; iBUS_RD = 1'b0; iBUS_WR = 1'b0;
      @(posedge iCLK); #1; check_val("corner_hold", oBUS_DATA, 32'h02);
      bus_read(32'hC, rdata); check_val("corner_baud_clamp", rdata, 32'd4);
      bus_read(32'h4, rdata); check_val("corner_pre2", rdata, 32'h02);
      @(negedge iCLK);
      iBUS_CE = 1'b0; iBUS_RD = 1'b1; iBUS_WR = 1'b1; iBUS_ADDR = 32'hC; iBUS_DATA = 32'h20;
      @(posedge iCLK); #1;
      iBUS_RD = 1'b0; iBUS_WR = 1'b0;
      @(posedge iCLK); #1; check_val("nocе_hold", oBUS_DATA, 32'h02);
      bus_read(32'hC, rdata); check_val("noce_baud", rdata, 32'd4);

      // Interrupt on tx_empty
      bus_write(32'h8, 32'h3);
      bus_read(32'h8, rdata);
`ifdef UART_RX_EN
      check_val("ctrl_rd", rdata, 32'h3);
`else
      check_val("ctrl_rd", rdata, 32'h2);
`endif
      @(posedge iCLK); #1; check_val("irq_txempty", {31'd0, oIRQ}, 32'd1);
      bus_write(32'hC, 32'd16);
      bus_write(32'h0, 32'h81);
      repeat (4) begin @(posedge iCLK); #1; end
      check_val("irq_busy_low", {31'd0, oIRQ}, 32'd0);
      repeat (170) begin @(posedge iCLK); #1; end
      check_val("irq_back", {31'd0, oIRQ}, 32'd1);
      bus_write(32'h8, 32'h0);

`ifdef UART_RX_EN
      // Receive path
      bus_write(32'h8, 32'h1);
      rx_send(8'hA3, 1'b1);
      bus_read(32'h4, rdata); check_val("rx_valid", rdata, 32'h06);
      check_val("rx_irq", {31'd0, oIRQ}, 32'd1);
      bus_read(32'h0, rdata); check_val("rx_data_a3", rdata, 32'hA3);
      @(posedge iCLK); #1; check_val("rx_irq_clear", {31'd0, oIRQ}, 32'd0);
      bus_read(32'h4, rdata); check_val("rx_valid_clear", rdata, 32'h02);
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      bus_read(32'h4, rdata); check_val("rx_overrun", rdata, 32'h0E);
      bus_read(32'h0, rdata); check_val("rx_second_byte", rdata, 32'h22);
      rx_send(8'h5A, 1'b0);
      bus_read(32'h4, rdata); check_val("rx_frame_err", rdata, 32'h2A);
      bus_write(32'h4, 32'h28);
      bus_read(32'h4, rdata); check_val("rx_flags_clear", rdata, 32'h02);
      bus_write(32'h8, 32'h0);
`endif

      // Reset in the middle of a frame
      bus_write(32'hC, 32'd16);
      bus_read(32'hC, rdata); check_val("pre_rst_baud", rdata, 32'd16);
      bus_write(32'h0, 32'hF0);
      repeat (40) begin @(posedge iCLK); #1; end
      check_val("pre_rst_txd_low", {31'd0, oUART_TXD}, 32'd0);
      iRST = 1'b0;
      #1;
      check_val("mid_rst_txd", {31'd0, oUART_TXD}, 32'd1);
      check_val("mid_rst_bus_data", oBUS_DATA, 32'd0);
      repeat (2) @(posedge iCLK);
      @(negedge iCLK); iRST = 1'b1;
      bus_read(32'h4, rdata); check_val("post_rst_status", rdata, 32'h02);
      bus_read(32'hC, rdata); check_val("post_rst_baud", rdata, 32'(BAUD_DIV));
      check_val("post_rst_txd", {31'd0, oUART_TXD}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
